// File: rtl/apb_cmd_pkg.sv
// Shared types and widths for the command-to-APB master bridge.
// Bus widths are set here so the command/response structs stay packed and fixed-size.
package apb_cmd_pkg;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int CMD_DEPTH_DFLT = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } apb_cmd_t;

    typedef struct packed {
        logic              write;
        logic [DATA_W-1:0] rdata;
    } apb_rsp_t;

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command, response and APB signal bundle of the bridge.
// The master modport is the bridge side; the slave modport is the environment side.
interface apb_cmd_master_if;
    import apb_cmd_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;

    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] prdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata,
        output paddr, pwdata, pwrite, psel, penable
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata,
        input  paddr, pwdata, pwrite, psel, penable
    );

endinterface

// File: rtl/apb_cmd_fifo.sv
// Generic synchronous FIFO on a packed element type; push is ignored when full,
// pop is ignored when empty, and a pushed entry is never bypassed to the output.
module apb_cmd_fifo
    import apb_cmd_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = apb_cmd_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  T                         din_i,
    input  logic                     pop_i,
    output T                         dout_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && (count_q != (AW+1)'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // NOTE: storage is reset (it is tiny) so the head reads zero straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/apb_cmd_master.sv
// Command-to-APB master bridge: command FIFO -> IDLE/SETUP/ACCESS sequencer -> 2-entry response buffer.
// Define APB_CMD_MASTER_B2B_EN to allow ACCESS->SETUP so psel stays high between transfers.
module apb_cmd_master
    import apb_cmd_pkg::*;
#(
    parameter int CMD_DEPTH = CMD_DEPTH_DFLT
) (
    input  logic              pclk,
    input  logic              presetn,
    apb_cmd_master_if.master  bus
);

    localparam int CW = $clog2(CMD_DEPTH) + 1;

    apb_state_e        state_q, state_d;
    logic              cmd_pend_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              pwrite_q;

    apb_cmd_t          cmd_in, cmd_head;
    apb_rsp_t          rsp_in, rsp_head;
    logic [CW-1:0]     cmd_cnt;
    logic [1:0]        rsp_cnt;
    logic              cmd_push, cmd_full, cmd_empty, issue;
    logic              rsp_push, rsp_pop, inflight, credit_ok;

    assign cmd_in    = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
    assign cmd_full  = (cmd_cnt == CW'(CMD_DEPTH));
    assign cmd_empty = (cmd_cnt == '0);
    assign cmd_push  = bus.cmd_valid && !cmd_full;

    apb_cmd_fifo #(.DEPTH(CMD_DEPTH), .T(apb_cmd_t)) u_cmd_fifo (
        .clk     (pclk),
        .rst_n   (presetn),
        .push_i  (cmd_push),
        .din_i   (cmd_in),
        .pop_i   (issue),
        .dout_o  (cmd_head),
        .count_o (cmd_cnt)
    );

    // Start a transfer only if a response slot is guaranteed when its ACCESS completes.
    assign inflight  = (state_q != IDLE);
    assign rsp_pop   = (rsp_cnt != '0) && bus.rsp_ready;
    assign credit_ok = ({1'b0, rsp_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, rsp_pop});

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_pend_q && credit_ok) begin
                    state_d = SETUP;
                    issue   = 1'b1;
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
`ifdef APB_CMD_MASTER_B2B_EN
                if (cmd_pend_q && credit_ok) begin
                    state_d = SETUP;
                    issue   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // cmd_pend_q is the queue's non-empty flag one cycle late; pops only happen on SETUP
    // entry, so it can never claim a command that has already left.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q    <= IDLE;
            cmd_pend_q <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pwrite_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_pend_q <= !cmd_empty;
            if (issue) begin
                paddr_q  <= cmd_head.addr;
                pwdata_q <= cmd_head.wdata;
                pwrite_q <= cmd_head.write;
            end
        end
    end

    assign rsp_push = (state_q == ACCESS);

    always_comb begin
        rsp_in       = '0;
        rsp_in.write = pwrite_q;
        if (!pwrite_q) begin
            rsp_in.rdata = bus.prdata;
        end
    end

    apb_cmd_fifo #(.DEPTH(2), .T(apb_rsp_t)) u_rsp_fifo (
        .clk     (pclk),
        .rst_n   (presetn),
        .push_i  (rsp_push),
        .din_i   (rsp_in),
        .pop_i   (rsp_pop),
        .dout_o  (rsp_head),
        .count_o (rsp_cnt)
    );

    assign bus.cmd_ready = !cmd_full;
    assign bus.rsp_valid = (rsp_cnt != '0);
    assign bus.rsp_write = rsp_head.write;
    assign bus.rsp_rdata = rsp_head.rdata;
    assign bus.psel      = (state_q != IDLE);
    assign bus.penable   = (state_q == ACCESS);
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.pwrite    = pwrite_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed and randomized checks of apb_cmd_master against a queue-based transaction model.
module tb_apb_cmd_master;
    import apb_cmd_pkg::*;

    localparam int DEPTH = 4;

    logic pclk    = 1'b0;
    logic presetn = 1'b0;
    always #5 pclk = ~pclk;

    apb_cmd_master_if bus ();

    apb_cmd_master #(.CMD_DEPTH(DEPTH)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    int        n_checks = 0;
    int        n_fail   = 0;
    apb_cmd_t  exp_cmd[$];
    apb_rsp_t  exp_rsp[$];
    apb_rsp_t  late_rsp;
    bit        late_vld;
    int        occ;
    bit        prev_cmd_ready;
    bit        prev_rsp_valid;
    int        n_access = 0;

    // Slave memory map: one fixed word, everything else a hash of the address.
    function automatic logic [DATA_W-1:0] slave_data(input logic [ADDR_W-1:0] a);
        if (a == 32'h20) return 32'h1234_5678;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_cmd.delete();
        exp_rsp.delete();
        late_vld       = 1'b0;
        occ            = 0;
        prev_cmd_ready = 1'b0;
        prev_rsp_valid = 1'b0;
    endtask

    // Advance to the next falling edge, account for the handshakes of the rising edge just
    // passed, then check the current cycle against the model.
    task automatic cycle();
        @(negedge pclk);
        if (presetn) begin
            if (bus.cmd_valid && prev_cmd_ready) begin
                exp_cmd.push_back('{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata});
                occ++;
            end
            if (bus.rsp_ready && prev_rsp_valid && exp_rsp.size() != 0) void'(exp_rsp.pop_front());
            if (late_vld) begin
                exp_rsp.push_back(late_rsp);
                late_vld = 1'b0;
            end
        end
        if (bus.psel && !bus.penable) begin
            occ--;
            check("setup_credit", 64'(exp_rsp.size() <= 1), 1);
        end
        check("cmd_ready", bus.cmd_ready, 64'(occ < DEPTH));
        if (bus.psel) begin
            check("psel_has_cmd", 64'(exp_cmd.size() != 0), 1);
            if (exp_cmd.size() != 0) begin
                check("paddr", bus.paddr, exp_cmd[0].addr);
                check("pwrite", bus.pwrite, exp_cmd[0].write);
                check("pwdata", bus.pwdata, exp_cmd[0].wdata);
                if (bus.penable) begin
                    late_rsp.write = exp_cmd[0].write;
                    late_rsp.rdata = exp_cmd[0].write ? '0 : slave_data(exp_cmd[0].addr);
                    late_vld = 1'b1;
                    void'(exp_cmd.pop_front());
                    n_access++;
                end
            end
        end
        check("rsp_valid", bus.rsp_valid, 64'(exp_rsp.size() != 0));
        if (bus.rsp_valid && exp_rsp.size() != 0) begin
            check("rsp_write", bus.rsp_write, exp_rsp[0].write);
            check("rsp_rdata", bus.rsp_rdata, exp_rsp[0].rdata);
        end
        prev_cmd_ready = bus.cmd_ready;
        prev_rsp_valid = bus.rsp_valid;
        bus.prdata     = slave_data(bus.paddr);
    endtask

    task automatic drive_cmd(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        while ((exp_cmd.size() != 0 || exp_rsp.size() != 0 || late_vld || bus.rsp_valid) && k < budget) begin
            cycle();
            k++;
        end
        check("drain_done", 64'(k < budget), 1);
    endtask

    initial begin
        logic [7:0] psel_tr, pen_tr, exp_psel_tr, exp_pen_tr;
        int k, a0;

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.prdata    = '0;
        model_reset();

        // Reset values
        repeat (2) cycle();
        check("rst_psel", bus.psel, 0);
        check("rst_penable", bus.penable, 0);
        check("rst_pwrite", bus.pwrite, 0);
        check("rst_paddr", bus.paddr, 0);
        check("rst_pwdata", bus.pwdata, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_write", bus.rsp_write, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        presetn = 1'b1;
        cycle();
        check("ready_after_rst", bus.cmd_ready, 1);

        // Single write: latency E2/E3/E4
        bus.rsp_ready = 1'b1;
        drive_cmd(1'b1, 32'h10, 32'hDEAD_BEEF);
        cycle();
        bus.cmd_valid = 1'b0;
        check("wr_psel_e0", bus.psel, 0);
        cycle();
        check("wr_psel_e1", bus.psel, 0);
        cycle();
        check("wr_psel_e2", bus.psel, 1);
        check("wr_pen_e2", bus.penable, 0);
        check("wr_paddr_e2", bus.paddr, 32'h10);
        check("wr_pwrite_e2", bus.pwrite, 1);
        cycle();
        check("wr_pen_e3", bus.penable, 1);
        cycle();
        check("wr_rsp_valid_e4", bus.rsp_valid, 1);
        check("wr_rsp_write_e4", bus.rsp_write, 1);
        check("wr_rsp_rdata_e4", bus.rsp_rdata, 0);
        cycle();
        check("wr_rsp_gone", bus.rsp_valid, 0);

        // Single read of the fixed slave word
        drive_cmd(1'b0, 32'h20, $urandom);
        cycle();
        bus.cmd_valid = 1'b0;
        repeat (2) cycle();
        check("rd_paddr", bus.paddr, 32'h20);
        check("rd_pwrite", bus.pwrite, 0);
        cycle();
        check("rd_pen", bus.penable, 1);
        cycle();
        check("rd_rsp_valid", bus.rsp_valid, 1);
        check("rd_rsp_write", bus.rsp_write, 0);
        check("rd_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
        drain(20);

        // Stalled responses: only two transfers may complete
        bus.rsp_ready = 1'b0;
        a0 = n_access;
        for (int i = 0; i < 4; i++) begin
            drive_cmd(1'b0, ADDR_W'(32'h100 + i * 4), $urandom);
            cycle();
        end
        bus.cmd_valid = 1'b0;
        repeat (20) cycle();
        check("stall_transfers", 64'(n_access - a0), 2);
        check("stall_psel", bus.psel, 0);
        drain(100);

        // Fill the queue while the bus is held off by a full response buffer
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_cmd(1'b1, ADDR_W'(32'h180 + i * 4), $urandom);
            cycle();
        end
        bus.cmd_valid = 1'b0;
        repeat (12) cycle();
        check("hold_psel", bus.psel, 0);
        for (int i = 0; i < 4; i++) begin
            drive_cmd(1'b1, ADDR_W'(32'h200 + i * 4), $urandom);
            cycle();
        end
        check("full_ready", bus.cmd_ready, 0);
        drive_cmd(1'b0, 32'h210, $urandom);
        cycle();
        check("full_ready_held", bus.cmd_ready, 0);
        bus.rsp_ready = 1'b1;
        k = 0;
        while (!(bus.psel && !bus.penable) && k < 20) begin
            cycle();
            k++;
        end
        check("first_setup_seen", 64'(k < 20), 1);
        check("ready_after_pop", bus.cmd_ready, 1);
        cycle();
        bus.cmd_valid = 1'b0;
        drain(100);

        // Three queued writes: psel/penable pattern
`ifdef APB_CMD_MASTER_B2B_EN
        exp_psel_tr = 8'b0011_1111;
        exp_pen_tr  = 8'b0010_1010;
`else
        exp_psel_tr = 8'b1101_1011;
        exp_pen_tr  = 8'b1001_0010;
`endif
        for (int i = 0; i < 3; i++) begin
            drive_cmd(1'b1, ADDR_W'(32'h300 + i * 4), $urandom);
            cycle();
        end
        bus.cmd_valid = 1'b0;
        k = 0;
        while (!bus.psel && k < 10) begin
            cycle();
            k++;
        end
        check("b2b_start", bus.psel, 1);
        for (int i = 0; i < 8; i++) begin
            psel_tr[i] = bus.psel;
            pen_tr[i]  = bus.penable;
            cycle();
        end
        check("b2b_psel_trace", psel_tr, exp_psel_tr);
        check("b2b_pen_trace", pen_tr, exp_pen_tr);
        drain(50);

        // Reset in the middle of ACCESS
        drive_cmd(1'b0, 32'h400, $urandom);
        cycle();
        bus.cmd_valid = 1'b0;
        k = 0;
        while (!(bus.psel && bus.penable) && k < 10) begin
            cycle();
            k++;
        end
        check("access_reached", 64'(k < 10), 1);
        presetn = 1'b0;
        #1;
        check("rst_async_psel", bus.psel, 0);
        check("rst_async_pen", bus.penable, 0);
        model_reset();
        repeat (2) cycle();
        presetn = 1'b1;
        cycle();
        check("post_rst_rsp_valid", bus.rsp_valid, 0);
        check("post_rst_ready", bus.cmd_ready, 1);
        repeat (4) cycle();

        // Randomized traffic with varying back-pressure
        for (int i = 0; i < 1600; i++) begin
            bus.cmd_valid = ($urandom_range(0, 99) < 60);
            bus.cmd_write = 1'($urandom_range(0, 1));
            bus.cmd_addr  = $urandom & 32'h0000_FFFC;
            bus.cmd_wdata = $urandom;
            bus.rsp_ready = ($urandom_range(0, 99) < ((i < 800) ? 80 : 35));
            cycle();
        end
        drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
